// File: rtl/adc_ser_tx.sv
// Multi-channel ADC serial-LVDS transmitter model: buffers one parallel sample,
// left-aligns it into an FW-bit frame and shifts it out over LW lanes per channel.
module adc_ser_tx #(
  parameter int CH        = 2,
  parameter int DW        = 14,
  parameter int FW        = 16,
  parameter int LW        = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic [DW-1:0]      pat_i,
  input  logic               slip_i,
  input  logic               clr_i,
  input  logic [CH*DW-1:0]   s_dat_i,
  input  logic               s_vld_i,
  output logic               s_rdy_o,
  output logic [CH*LW-1:0]   dat_o,
  output logic               fr_o,
  output logic               underrun_o
);

  localparam int PW = FW / LW;
  localparam int BW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(PW - 1);
  localparam logic [BW-1:0] B_HALF = BW'(PW / 2);
  localparam logic [DW-1:0] CHK_A  = DW'({((DW + 1) / 2){2'b10}});

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STRETCH} state_t;

  state_t              state_q;
  logic [BW-1:0]       b_q;
  logic [CH*DW-1:0]    hold_q;
  logic                hold_full_q;
  logic [CH*DW-1:0]    last_q;
  logic [CH*DW-1:0]    ramp_q;
  logic                chk_q;
  logic [1:0]          last_mode_q;
  logic                slip_pend_q;
  logic [CH*FW-1:0]    shift_q;
  logic [CH*LW-1:0]    dat_q;
  logic                fr_q;
  logic                underrun_q;

  logic                stretch, load, consume, accept, under_d;
  logic [BW-1:0]       b_nx;
  logic [CH*DW-1:0]    src_d;
  logic [CH*FW-1:0]    word_d;

  function automatic logic [LW-1:0] beat_of(input logic [FW-1:0] w, input logic [BW-1:0] k);
    logic [FW-1:0] t;
    if (MSB_FIRST) begin
      t = w << (LW * int'(k));
      return t[FW-1 -: LW];
    end else begin
      t = w >> (LW * int'(k));
      return t[LW-1:0];
    end
  endfunction

  function automatic logic [CH*LW-1:0] beats(input logic [CH*FW-1:0] w, input logic [BW-1:0] k);
    logic [CH*LW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*LW +: LW] = beat_of(w[c*FW +: FW], k);
    return r;
  endfunction

  // A pending slip holds the counter on the last beat for exactly one extra cycle.
  assign stretch = en_i && (state_q == ST_RUN) && (b_q == B_LAST) && (slip_pend_q || slip_i);
  assign load    = en_i && ((state_q == ST_IDLE) || ((b_q == B_LAST) && !stretch));
  assign consume = load && (mode_i == 2'd0) && hold_full_q;
  assign s_rdy_o = !hold_full_q || consume;
  assign accept  = s_vld_i && s_rdy_o;
  assign b_nx    = b_q + BW'(1);

  always_comb begin
    src_d   = last_q;
    under_d = 1'b0;
    word_d  = '0;
    case (mode_i)
      2'd0: begin
        if (hold_full_q) src_d = hold_q;
        else             under_d = 1'b1;
      end
      2'd1: src_d = {CH{pat_i}};
      2'd2: begin
        for (int c = 0; c < CH; c++)
          src_d[c*DW +: DW] = (last_mode_q == 2'd2) ? ramp_q[c*DW +: DW] + DW'(1) : '0;
      end
      default: src_d = {CH{chk_q ? ~CHK_A : CHK_A}};
    endcase
    for (int c = 0; c < CH; c++)
      word_d[c*FW +: FW] = FW'(src_d[c*DW +: DW]) << (FW - DW);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ramp_q      <= '0;
      chk_q       <= 1'b0;
      last_mode_q <= 2'd0;
      slip_pend_q <= 1'b0;
      shift_q     <= '0;
      dat_q       <= '0;
      fr_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (accept) hold_q <= s_dat_i;
      hold_full_q <= accept || (hold_full_q && !consume);

      if (load && under_d) underrun_q <= 1'b1;
      else if (clr_i)      underrun_q <= 1'b0;

      if (!en_i) begin
        state_q     <= ST_IDLE;
        b_q         <= '0;
        shift_q     <= '0;
        dat_q       <= '0;
        fr_q        <= 1'b0;
        slip_pend_q <= 1'b0;
      end else if (load) begin
        state_q     <= ST_RUN;
        b_q         <= '0;
        shift_q     <= word_d;
        dat_q       <= beats(word_d, BW'(0));
        fr_q        <= 1'b1;
        // Slips arriving while the stretched beat is on the wire are dropped.
        slip_pend_q <= (state_q == ST_STRETCH) ? 1'b0 : (slip_pend_q || slip_i);
        last_mode_q <= mode_i;
        case (mode_i)
          2'd0:    last_q <= src_d;
          2'd2:    ramp_q <= src_d;
          2'd3:    chk_q  <= !chk_q;
          default: ;
        endcase
      end else if (stretch) begin
        state_q     <= ST_STRETCH;
        slip_pend_q <= 1'b0;
      end else begin
        b_q         <= b_nx;
        dat_q       <= beats(shift_q, b_nx);
        fr_q        <= (b_nx < B_HALF);
        slip_pend_q <= slip_pend_q || slip_i;
      end
    end
  end

  assign dat_o      = dat_q;
  assign fr_o       = fr_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_adc_ser_tx.sv
// Bench for adc_ser_tx: frame monitor + expected-sample queue, a vector table,
// and hand sequences for streaming, underrun, ramp wrap, slip, abort and reset.
module tb_adc_ser_tx;
  localparam int CH = 2;
  localparam int DW = 14;
  localparam int FW = 16;
  localparam int LW = 2;
  localparam int PW = FW / LW;

  logic              clk = 1'b0;
  logic              rst, en, slip, clr, s_vld;
  logic [1:0]        mode;
  logic [DW-1:0]     pat;
  logic [CH*DW-1:0]  s_dat;
  logic              s_rdy, fr, underrun;
  logic [CH*LW-1:0]  dat;

  adc_ser_tx #(.CH(CH), .DW(DW), .FW(FW), .LW(LW), .MSB_FIRST(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .pat_i(pat),
    .slip_i(slip), .clr_i(clr), .s_dat_i(s_dat), .s_vld_i(s_vld),
    .s_rdy_o(s_rdy), .dat_o(dat), .fr_o(fr), .underrun_o(underrun)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [CH*DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard: rebuild each frame from the lanes and compare to the queue head
  bit           mon_on = 1'b0;
  int           cap_idx = -1;
  logic         prev_fr = 1'b0;
  logic [FW-1:0] cap_w[CH];
  logic [CH*DW-1:0] e;

  always @(negedge clk) begin
    if (!mon_on) begin
      cap_idx = -1;
      prev_fr = 1'b0;
    end else begin
      if (fr && !prev_fr) cap_idx = 0;
      if (cap_idx >= 0) begin
        for (int c = 0; c < CH; c++) cap_w[c] = {cap_w[c][FW-LW-1:0], dat[c*LW +: LW]};
        cap_idx++;
        if (cap_idx == PW) begin
          cap_idx = -1;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL frame: got unexpected frame ch0=%0h ch1=%0h want none", cap_w[0], cap_w[1]);
          end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < CH; c++)
              check($sformatf("frame_ch%0d", c), cap_w[c], {e[c*DW +: DW], {(FW-DW){1'b0}}});
          end
        end
      end
      prev_fr = fr;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CH*DW-1:0] d, output int at);
    int   n;
    logic took;
    n = 0;
    took = 1'b0;
    s_dat = d;
    s_vld = 1'b1;
    while (!took && n < 100) begin
      #3;
      took = s_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    s_vld = 1'b0;
    at = cyc;
    if (!took) begin
      n_chk++;
      n_err++;
      $display("FAIL push: sample %0h not accepted, got no ready want ready within 100 cycles", d);
    end
  endtask

  task automatic one_frame();
    en = 1'b1;
    tick(PW);
    en = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [DW-1:0]    pat;
    logic [CH*DW-1:0] smp;
    logic [CH*DW-1:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   exp_b[8] = '{2, 2, 2, 2, 3, 3, 0, 0};
  logic [CH*DW-1:0] ss[4];
  logic [CH*DW-1:0] s_u;
  int   at, a1, a2, a3, rdy_hi;
  int   lens[4] = '{8, 9, 8, 8};
  logic [32:0] fr_seq, fr_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 14'h0000, {14'h0000, 14'h2ABC}, {14'h0000, 14'h2ABC}};
    tbl[1] = '{2'd0, 14'h0000, {14'h0001, 14'h3FFF}, {14'h0001, 14'h3FFF}};
    tbl[2] = '{2'd0, 14'h0000, {14'h1234, 14'h0000}, {14'h1234, 14'h0000}};
    tbl[3] = '{2'd1, 14'h1A5A, {14'h0000, 14'h0000}, {14'h1A5A, 14'h1A5A}};
    tbl[4] = '{2'd3, 14'h0000, {14'h0000, 14'h0000}, {14'h2AAA, 14'h2AAA}};
    tbl[5] = '{2'd3, 14'h0000, {14'h0000, 14'h0000}, {14'h1555, 14'h1555}};
    tbl[6] = '{2'd2, 14'h0000, {14'h0000, 14'h0000}, {14'h0000, 14'h0000}};
    tbl[7] = '{2'd2, 14'h0000, {14'h0000, 14'h0000}, {14'h0001, 14'h0001}};
    tbl[8] = '{2'd2, 14'h0000, {14'h0000, 14'h0000}, {14'h0002, 14'h0002}};
    tbl[9] = '{2'd1, 14'h2001, {14'h0000, 14'h0000}, {14'h2001, 14'h2001}};
    ss[0] = {14'h0111, 14'h3001};
    ss[1] = {14'h0222, 14'h2002};
    ss[2] = {14'h0333, 14'h1003};
    ss[3] = {14'h0444, 14'h0004};
    s_u   = {14'h0123, 14'h3210};

    rst = 1'b1; en = 1'b0; slip = 1'b0; clr = 1'b0; s_vld = 1'b0;
    mode = 2'd0; pat = '0; s_dat = '0;
    tick(3);
    check("rst_dat", dat, 0);
    check("rst_fr", fr, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_rdy", s_rdy, 1);
    rst = 1'b0;
    tick(1);
    mon_on = 1'b1;

    // single 2ABC frame checked beat by beat
    push({14'h0000, 14'h2ABC}, at);
    exp_q.push_back({14'h0000, 14'h2ABC});
    en = 1'b1;
    for (int k = 0; k < PW; k++) begin
      tick(1);
      check($sformatf("beat%0d_ch0", k), dat[LW-1:0], exp_b[k]);
      check($sformatf("beat%0d_ch1", k), dat[2*LW-1:LW], 0);
      check($sformatf("beat%0d_fr", k), fr, (k < PW/2) ? 1 : 0);
    end
    en = 1'b0;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      mode = tbl[i].mode;
      pat  = tbl[i].pat;
      if (tbl[i].mode == 2'd0) push(tbl[i].smp, at);
      exp_q.push_back(tbl[i].exp);
      one_frame();
      check($sformatf("tbl%0d_underrun", i), underrun, 0);
    end

    // back-to-back stream with s_vld held
    mode = 2'd0;
    push(ss[0], at);
    for (int i = 0; i < 4; i++) exp_q.push_back(ss[i]);
    fork
      begin
        push(ss[1], a1);
        push(ss[2], a2);
        push(ss[3], a3);
      end
      begin
        en = 1'b1;
        tick(4 * PW);
        en = 1'b0;
      end
      begin
        rdy_hi = 0;
        repeat (4 * PW) begin
          #3;
          if (s_rdy) rdy_hi++;
          @(posedge clk);
          #1;
        end
      end
    join
    tick(2);
    check("stream_gap12", a2 - a1, PW);
    check("stream_gap23", a3 - a2, PW);
    check("stream_rdy_cycles", rdy_hi, 11);
    check("stream_underrun", underrun, 0);

    // underrun: second frame repeats the only sample
    push(s_u, at);
    exp_q.push_back(s_u);
    exp_q.push_back(s_u);
    en = 1'b1;
    tick(PW);
    check("underrun_first", underrun, 0);
    tick(PW);
    en = 1'b0;
    tick(1);
    check("underrun_set", underrun, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("underrun_clr", underrun, 0);
    exp_q.push_back(s_u);
    clr = 1'b1;
    en = 1'b1;
    tick(1);
    clr = 1'b0;
    check("underrun_set_wins", underrun, 1);
    tick(PW - 1);
    en = 1'b0;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("underrun_clr2", underrun, 0);

    // ramp restart and wrap
    mode = 2'd2;
    exp_q.push_back('0);
    one_frame();
    force dut.ramp_q = {14'h3FFF, 14'h3FFF};
    #1;
    release dut.ramp_q;
    exp_q.push_back('0);
    exp_q.push_back({14'h0001, 14'h0001});
    en = 1'b1;
    tick(2 * PW);
    en = 1'b0;
    tick(1);

    // slip: one 9-cycle frame, a second slip during the stretch is ignored
    mode = 2'd1;
    pat = 14'h0F0F;
    for (int i = 0; i < 4; i++) exp_q.push_back({14'h0F0F, 14'h0F0F});
    begin
      int idx;
      idx = 0;
      for (int f = 0; f < 4; f++)
        for (int p = 0; p < lens[f]; p++) begin
          fr_exp[idx] = (p < PW/2);
          idx++;
        end
    end
    en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick(1);
      fr_seq[i] = fr;
      slip = (i == 9) || (i == 16);
    end
    slip = 1'b0;
    en = 1'b0;
    tick(1);
    check("slip_fr_pattern", fr_seq, fr_exp);

    // abort mid-frame, restart, reset mid-frame
    mon_on = 1'b0;
    tick(1);
    mode = 2'd0;
    en = 1'b1;
    tick(4);
    check("idle_start_underrun", underrun, 1);
    check("abort_pre_fr", fr, 1);
    en = 1'b0;
    tick(1);
    check("abort_dat", dat, 0);
    check("abort_fr", fr, 0);
    mode = 2'd1;
    pat = 14'h3FFF;
    tick(1);
    en = 1'b1;
    tick(1);
    check("restart_fr", fr, 1);
    check("restart_beat0", dat, 4'hF);
    push(ss[0], at);
    check("hold_full_rdy", s_rdy, 0);
    rst = 1'b1;
    tick(1);
    check("rst_mid_dat", dat, 0);
    check("rst_mid_fr", fr, 0);
    check("rst_mid_underrun", underrun, 0);
    check("rst_mid_s_rdy", s_rdy, 1);
    rst = 1'b0;
    tick(1);
    check("post_rst_fr", fr, 1);
    check("post_rst_beat0", dat, 4'hF);
    en = 1'b0;
    tick(2);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
